// File: rtl/matrix5x7_scan.sv
// Column-multiplexed scanner for a 5x7 dot-matrix display.
// Double-buffers the glyph so a new pattern only takes effect at a frame boundary.
module matrix5x7_scan #(
    parameter int DWELL      = 50000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [34:0] pattern_in,
    input  logic        load,
    input  logic        blank,
    output logic [6:0]  row,
    output logic [4:0]  col,
    output logic        frame_done,
    output logic        pending
);

    localparam int            DW         = $clog2(DWELL);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [6:0]    ROW_OFF    = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [4:0]    COL_OFF    = ACTIVE_LOW ? 5'h1F : 5'h00;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [2:0]    colc_q, colc_d;
    logic [34:0]   frame_q, frame_d;
    logic [34:0]   shadow_q, shadow_d;
    logic          pending_q, pending_d;
    logic          frame_done_q, frame_done_d;
    logic [6:0]    row_q, row_d;
    logic [4:0]    col_q, col_d;
    logic          boundary_s;
    logic [6:0]    lit_row_s;
    logic [4:0]    lit_col_s;

    // Row r of column k lives at bit 34-7k-r, so the top row is the MSB of each group.
    function automatic logic [6:0] column_bits(input logic [34:0] frame, input logic [2:0] k);
        logic [6:0] bits;
        for (int r = 0; r < 7; r++) begin
            bits[r] = frame[34 - 7 * int'(k) - r];
        end
        return bits;
    endfunction

    // Scan sequencing: one BLANK cycle, then DWELL SHOW cycles per column.
    always_comb begin
        state_d    = state_q;
        dwell_d    = dwell_q;
        colc_d     = colc_q;
        boundary_s = 1'b0;
        case (state_q)
            ST_BLANK: begin
                state_d = ST_SHOW;
                dwell_d = '0;
            end
            ST_SHOW: begin
                if (dwell_q == DWELL_LAST) begin
                    state_d    = ST_BLANK;
                    dwell_d    = '0;
                    colc_d     = (colc_q == 3'd4) ? 3'd0 : colc_q + 3'd1;
                    boundary_s = (colc_q == 3'd4);
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            default: begin
                state_d = ST_BLANK;
                dwell_d = '0;
                colc_d  = 3'd0;
            end
        endcase
    end

    // Double buffering: a load on the boundary edge bypasses the shadow and never pends.
    always_comb begin
        frame_d      = frame_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        frame_done_d = boundary_s;
        if (boundary_s) begin
            if (load) begin
                frame_d   = pattern_in;
                shadow_d  = pattern_in;
                pending_d = 1'b0;
            end else if (pending_q) begin
                frame_d   = shadow_q;
                pending_d = 1'b0;
            end else begin
                pending_d = 1'b0;
            end
        end else if (load) begin
            shadow_d  = pattern_in;
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    // Output drive computed from the next state so the registered pins match the current state.
    // Entry into SHOW always comes from BLANK, so frame_q already holds any boundary update.
    always_comb begin
        lit_row_s = column_bits(frame_q, colc_d);
        lit_col_s = 5'b00001 << colc_d;
        row_d     = ROW_OFF;
        col_d     = COL_OFF;
        if (!blank && (state_d == ST_SHOW)) begin
            row_d = ACTIVE_LOW ? ~lit_row_s : lit_row_s;
            col_d = ACTIVE_LOW ? ~lit_col_s : lit_col_s;
        end else begin
            row_d = ROW_OFF;
            col_d = COL_OFF;
        end
    end

    // State, buffer and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_BLANK;
            dwell_q      <= '0;
            colc_q       <= 3'd0;
            frame_q      <= 35'd0;
            shadow_q     <= 35'd0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            row_q        <= ROW_OFF;
            col_q        <= COL_OFF;
        end else begin
            state_q      <= state_d;
            dwell_q      <= dwell_d;
            colc_q       <= colc_d;
            frame_q      <= frame_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            row_q        <= row_d;
            col_q        <= col_d;
        end
    end

    assign row        = row_q;
    assign col        = col_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

endmodule
